// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the memory arbiter and its requesters: the mem_sys
// request bus, the four mem_sys operation modes and the port identifier.
package BusTypes;

  // Request bus into mem_sys: array id, word offset, write/remap data, mode.
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
    logic [1:0]  mode;
  } mem_in_bus_t;

  localparam logic [1:0] MEM_READ  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_ALLOC = 2'b10;
  localparam logic [1:0] MEM_REMAP = 2'b11;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_EXEC  = 1'b1
  } port_t;

  // Reads and mallocs hand mem_sys.data_out back; writes and remaps return 0.
  function automatic logic returns_data(input logic [1:0] mode);
    return (mode == MEM_READ) || (mode == MEM_ALLOC);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. Grants are combinational from the
// request lines and the pointer; the pointer moves to the losing side after
// every grant so a held request wins on the very next cycle.
module rr_arb2
  import BusTypes::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_f,
  input  logic req_x,
  output logic gnt_f,
  output logic gnt_x
);

  port_t rr_ptr_reg;
  port_t rr_ptr_next;

  // Grant a lone requester; on contention the pointer decides. Nothing is
  // granted while reset is held.
  always_comb begin
    gnt_f = reset_n && req_f && (!req_x || (rr_ptr_reg == PORT_FETCH));
    gnt_x = reset_n && req_x && (!req_f || (rr_ptr_reg == PORT_EXEC));
  end

  // Point at the port that was not granted; hold when idle.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (gnt_f) begin
      rr_ptr_next = PORT_EXEC;
    end else if (gnt_x) begin
      rr_ptr_next = PORT_FETCH;
    end
  end

  // Pointer register with synchronous active-low reset to the initial priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_reg <= port_t'(INIT_PRIO);
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and execute units onto the single mem_sys port.
// S1 registers the granted request onto mem_bus; S2 carries the tags one
// cycle further so mem_sys.data_out can be steered to the originating port.
// mem_sys handles one operation per cycle in order, so no hazard logic.
module mem_arbiter
  import BusTypes::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req_valid,
  output logic        f_req_ready,
  input  logic [31:0] f_addr,
  input  logic [31:0] f_offset,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  input  logic        x_req_valid,
  output logic        x_req_ready,
  input  mem_in_bus_t x_req,
  output logic        x_rsp_valid,
  output logic [31:0] x_rsp_data,
  output mem_in_bus_t mem_bus,
  input  logic [31:0] mem_data_out
);

  logic gnt_f;
  logic gnt_x;

  rr_arb2 #(
    .INIT_PRIO(INIT_PRIO)
  ) u_rr_arb2 (
    .clk    (clk),
    .reset_n(reset_n),
    .req_f  (f_req_valid),
    .req_x  (x_req_valid),
    .gnt_f  (gnt_f),
    .gnt_x  (gnt_x)
  );

  assign f_req_ready = gnt_f;
  assign x_req_ready = gnt_x;

  // S1 (issue) state
  mem_in_bus_t mem_bus_reg;
  mem_in_bus_t mem_bus_next;
  logic        s1_vld_reg;
  logic        s1_vld_next;
  port_t       s1_port_reg;
  port_t       s1_port_next;
  logic [1:0]  s1_mode_reg;
  logic [1:0]  s1_mode_next;

  // S2 (return) state
  logic        s2_vld_reg;
  port_t       s2_port_reg;
  logic [1:0]  s2_mode_reg;

  // Build the next mem_sys request; an idle cycle issues an all-zero read.
  always_comb begin
    mem_bus_next = '0;
    s1_vld_next  = 1'b0;
    s1_port_next = PORT_FETCH;
    s1_mode_next = MEM_READ;
    if (gnt_f) begin
      mem_bus_next.address = f_addr;
      mem_bus_next.offset  = f_offset;
      mem_bus_next.data    = 32'd0;
      mem_bus_next.mode    = MEM_READ;
      s1_vld_next          = 1'b1;
      s1_port_next         = PORT_FETCH;
      s1_mode_next         = MEM_READ;
    end else if (gnt_x) begin
      mem_bus_next = x_req;
      s1_vld_next  = 1'b1;
      s1_port_next = PORT_EXEC;
      s1_mode_next = x_req.mode;
    end
  end

  // S1 register: drives mem_sys directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_bus_reg <= '0;
      s1_vld_reg  <= 1'b0;
      s1_port_reg <= PORT_FETCH;
      s1_mode_reg <= MEM_READ;
    end else begin
      mem_bus_reg <= mem_bus_next;
      s1_vld_reg  <= s1_vld_next;
      s1_port_reg <= s1_port_next;
      s1_mode_reg <= s1_mode_next;
    end
  end

  assign mem_bus = mem_bus_reg;

  // S2 register: tags line up with mem_sys.data_out for this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_vld_reg  <= 1'b0;
      s2_port_reg <= PORT_FETCH;
      s2_mode_reg <= MEM_READ;
    end else begin
      s2_vld_reg  <= s1_vld_reg;
      s2_port_reg <= s1_port_reg;
      s2_mode_reg <= s1_mode_reg;
    end
  end

  // Response steering: index 0 is fetch, index 1 is execute.
  logic [1:0]  rsp_valid_vec;
  logic [31:0] rsp_data_vec [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      localparam port_t PORT_ID = (gi == 0) ? PORT_FETCH : PORT_EXEC;
      assign rsp_valid_vec[gi] = s2_vld_reg && (s2_port_reg == PORT_ID);
      assign rsp_data_vec[gi]  = (rsp_valid_vec[gi] && returns_data(s2_mode_reg))
                                 ? mem_data_out : 32'd0;
    end
  endgenerate

  assign f_rsp_valid = rsp_valid_vec[0];
  assign f_rsp_data  = rsp_data_vec[0];
  assign x_rsp_valid = rsp_valid_vec[1];
  assign x_rsp_data  = rsp_data_vec[1];

endmodule
